// File: rtl/vx_index_reorder_pkg.sv
// Shared helpers for the index reorder buffer.
package vx_index_reorder_pkg;

  // Index width for a SIZE-entry ring; never narrower than one bit.
  function automatic int unsigned log2up(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_index_reorder_if.sv
// Allocate / fill / drain bus of the index reorder buffer.
interface vx_index_reorder_if #(
  parameter int DATAW = 1,
  parameter int ADDRW = 3
);
  logic             alloc_valid;
  logic             alloc_ready;
  logic [ADDRW-1:0] alloc_idx;
  logic             fill_valid;
  logic [ADDRW-1:0] fill_idx;
  logic [DATAW-1:0] fill_data;
  logic             drain_valid;
  logic             drain_ready;
  logic [ADDRW-1:0] drain_idx;
  logic [DATAW-1:0] drain_data;
  logic             fill_err;
  logic             empty;
  logic             full;

  // Issuer / consumer side.
  modport master (
    output alloc_valid, fill_valid, fill_idx, fill_data, drain_ready,
    input  alloc_ready, alloc_idx, drain_valid, drain_idx, drain_data,
           fill_err, empty, full
  );

  // Reorder buffer side.
  modport slave (
    input  alloc_valid, fill_valid, fill_idx, fill_data, drain_ready,
    output alloc_ready, alloc_idx, drain_valid, drain_idx, drain_data,
           fill_err, empty, full
  );
endinterface

// File: rtl/vx_index_reorder_ptr.sv
// Wrap-bit ring pointer pair: head/tail with empty and full flags.
module vx_index_reorder_ptr #(
  parameter int ADDRW = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  output logic [ADDRW:0] head,
  output logic [ADDRW:0] tail,
  output logic           empty,
  output logic           full
);
  logic [ADDRW:0] head_q, head_d;
  logic [ADDRW:0] tail_q, tail_d;

  // Advance each pointer on its own event; wrap is natural modulo 2*SIZE.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (pop)  head_d = head_q + 1'b1;
    if (push) tail_d = tail_q + 1'b1;
  end

  // Pointer registers, cleared by synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign head  = head_q;
  assign tail  = tail_q;
  assign empty = (head_q == tail_q);
  assign full  = (head_q[ADDRW-1:0] == tail_q[ADDRW-1:0]) && (head_q[ADDRW] != tail_q[ADDRW]);
endmodule

// File: rtl/vx_index_reorder.sv
// Tag-ordered completion buffer: ring-order allocation, out-of-order fill,
// in-order drain.
module vx_index_reorder
  import vx_index_reorder_pkg::*;
#(
  parameter int DATAW = 1,
  parameter int SIZE  = 8,
  parameter int ADDRW = log2up(SIZE)
) (
  input  logic               clk,
  input  logic               reset,
  vx_index_reorder_if.slave  bus
);
  localparam int PTRW = ADDRW + 1;

  logic [PTRW-1:0]  head, tail;
  logic             empty, full;
  logic [ADDRW-1:0] head_idx, tail_idx;
  logic             alloc_fire, drain_fire, fill_hit, drain_valid;

  logic [SIZE-1:0]  alloc_q, alloc_d;
  logic [SIZE-1:0]  filled_q, filled_d;
  logic             fill_err_q, fill_err_d;
  logic [DATAW-1:0] data_q [SIZE];
  logic [DATAW-1:0] data_d [SIZE];

  assign head_idx    = head[ADDRW-1:0];
  assign tail_idx    = tail[ADDRW-1:0];
  assign drain_valid = !empty && filled_q[head_idx];
  assign alloc_fire  = bus.alloc_valid && !full;
  assign drain_fire  = drain_valid && bus.drain_ready;
  assign fill_hit    = alloc_q[bus.fill_idx] && !filled_q[bus.fill_idx];

  vx_index_reorder_ptr #(.ADDRW(ADDRW)) ptr_i (
    .clk   (clk),
    .reset (reset),
    .push  (alloc_fire),
    .pop   (drain_fire),
    .head  (head),
    .tail  (tail),
    .empty (empty),
    .full  (full)
  );

  // Slot bookkeeping: drain frees head, alloc claims tail, fill marks its slot.
  // Drained and allocated slots never coincide because full blocks allocation.
  always_comb begin
    alloc_d    = alloc_q;
    filled_d   = filled_q;
    fill_err_d = fill_err_q;
    if (drain_fire) begin
      alloc_d[head_idx]  = 1'b0;
      filled_d[head_idx] = 1'b0;
    end
    if (alloc_fire) begin
      alloc_d[tail_idx]  = 1'b1;
      filled_d[tail_idx] = 1'b0;
    end
    if (bus.fill_valid) begin
      if (fill_hit) filled_d[bus.fill_idx] = 1'b1;
      else          fill_err_d = 1'b1;
    end
  end

  // Payload storage: only legal fills write; read port follows head.
  always_comb begin
    data_d = data_q;
    if (bus.fill_valid && fill_hit) data_d[bus.fill_idx] = bus.fill_data;
  end

  // Status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      alloc_q    <= '0;
      filled_q   <= '0;
      fill_err_q <= 1'b0;
    end else begin
      alloc_q    <= alloc_d;
      filled_q   <= filled_d;
      fill_err_q <= fill_err_d;
    end
  end

  // Payload registers need no reset; validity lives in filled_q.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign bus.alloc_ready = !full;
  assign bus.alloc_idx   = tail_idx;
  assign bus.drain_valid = drain_valid;
  assign bus.drain_idx   = head_idx;
  assign bus.drain_data  = data_q[head_idx];
  assign bus.fill_err    = fill_err_q;
  assign bus.empty       = empty;
  assign bus.full        = full;
endmodule

// File: tb/tb_vx_index_reorder.sv
// Self-checking bench for vx_index_reorder (SIZE=4, DATAW=8).
module tb_vx_index_reorder;
  localparam int SIZE  = 4;
  localparam int DATAW = 8;
  localparam int ADDRW = 2;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  vx_index_reorder_if #(.DATAW(DATAW), .ADDRW(ADDRW)) bus ();

  vx_index_reorder #(.DATAW(DATAW), .SIZE(SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: ordered queue of outstanding slots plus per-slot state.
  int         q[$];
  bit         m_alloc [SIZE];
  bit         m_filled[SIZE];
  logic [7:0] m_data  [SIZE];
  int         next_idx;
  bit         m_err;

  function automatic bit exp_dv();
    return (q.size() > 0) && m_filled[q[0]];
  endfunction

  function automatic bit exp_full();
    return q.size() == SIZE;
  endfunction

  // Advance one clock and update the model from the inputs seen at the edge.
  task automatic tick();
    bit a, d;
    int fi;
    @(posedge clk);
    if (!reset) begin
      q.delete();
      for (int i = 0; i < SIZE; i++) begin m_alloc[i] = 0; m_filled[i] = 0; end
      next_idx = 0;
      m_err    = 0;
    end else begin
      d = exp_dv() && bus.drain_ready;
      a = bus.alloc_valid && (q.size() < SIZE);
      if (bus.fill_valid) begin
        fi = int'(bus.fill_idx);
        if (m_alloc[fi] && !m_filled[fi]) begin
          m_filled[fi] = 1; m_data[fi] = bus.fill_data;
        end else m_err = 1;
      end
      if (d) begin
        m_alloc[q[0]] = 0; m_filled[q[0]] = 0;
        void'(q.pop_front());
      end
      if (a) begin
        q.push_back(next_idx);
        m_alloc[next_idx] = 1; m_filled[next_idx] = 0;
        next_idx = (next_idx + 1) % SIZE;
      end
    end
    #1;
  endtask

  task automatic idle();
    bus.alloc_valid = 0; bus.fill_valid = 0; bus.fill_idx = '0;
    bus.fill_data = '0; bus.drain_ready = 0;
  endtask

  task automatic do_reset(input int n);
    idle();
    reset = 0;
    repeat (n) tick();
    reset = 1;
  endtask

  task automatic test_reset();
    do_reset(3);
    #1;
    checks++; if (bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready got %b exp 1", bus.alloc_ready); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bus.full); end
    checks++; if (bus.drain_valid !== 1'b0) begin errors++; $display("FAIL reset_drain_valid got %b exp 0", bus.drain_valid); end
    checks++; if (bus.fill_err !== 1'b0) begin errors++; $display("FAIL reset_fill_err got %b exp 0", bus.fill_err); end
    checks++; if (bus.alloc_idx !== 2'd0) begin errors++; $display("FAIL reset_alloc_idx got %0d exp 0", bus.alloc_idx); end
    checks++; if (bus.drain_idx !== 2'd0) begin errors++; $display("FAIL reset_drain_idx got %0d exp 0", bus.drain_idx); end
  endtask

  task automatic test_in_order();
    int cnt;
    for (int i = 0; i < 4; i++) begin
      idle(); bus.alloc_valid = 1; #1;
      checks++; if (bus.alloc_idx !== 2'(i)) begin errors++; $display("FAIL inorder_alloc_idx got %0d exp %0d", bus.alloc_idx, i); end
      tick();
    end
    idle(); #1;
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL inorder_full got %b exp 1", bus.full); end
    for (int i = 0; i < 4; i++) begin
      idle(); bus.fill_valid = 1; bus.fill_idx = 2'(i); bus.fill_data = 8'hA0 + 8'(i); tick();
    end
    idle(); bus.drain_ready = 1;
    cnt = 0;
    for (int t = 0; t < 10 && cnt < 4; t++) begin
      #1;
      if (bus.drain_valid === 1'b1) begin
        checks++;
        if (bus.drain_data !== 8'hA0 + 8'(cnt) || bus.drain_idx !== 2'(cnt)) begin
          errors++; $display("FAIL inorder_drain got idx %0d data %h exp idx %0d data %h", bus.drain_idx, bus.drain_data, cnt, 8'hA0 + 8'(cnt));
        end
        cnt++;
      end
      tick();
    end
    checks++; if (cnt != 4) begin errors++; $display("FAIL inorder_drain_count got %0d exp 4", cnt); end
    idle(); #1;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL inorder_empty got %b exp 1", bus.empty); end
  endtask

  task automatic test_out_of_order();
    logic [7:0] dat [3];
    int         ord [3];
    dat = '{8'hC2, 8'hC0, 8'hC1}; ord = '{2, 0, 1};
    do_reset(1);
    for (int i = 0; i < 3; i++) begin idle(); bus.alloc_valid = 1; tick(); end
    idle(); bus.drain_ready = 1;
    for (int i = 0; i < 3; i++) begin
      bus.fill_valid = 1; bus.fill_idx = 2'(ord[i]); bus.fill_data = dat[i]; #1;
      checks++;
      if (bus.drain_valid !== (i == 2)) begin errors++; $display("FAIL ooo_drain_valid step %0d got %b exp %b", i, bus.drain_valid, (i == 2)); end
      if (i == 2) begin
        checks++; if (bus.drain_data !== 8'hC0 || bus.drain_idx !== 2'd0) begin errors++; $display("FAIL ooo_head0 got idx %0d data %h exp idx 0 data c0", bus.drain_idx, bus.drain_data); end
      end
      tick();
    end
    bus.fill_valid = 0;
    for (int i = 1; i < 3; i++) begin
      #1;
      checks++;
      if (bus.drain_valid !== 1'b1 || bus.drain_idx !== 2'(i) || bus.drain_data !== 8'hC0 + 8'(i)) begin
        errors++; $display("FAIL ooo_head%0d got v %b idx %0d data %h exp v 1 idx %0d data %h", i, bus.drain_valid, bus.drain_idx, bus.drain_data, i, 8'hC0 + 8'(i));
      end
      tick();
    end
    idle(); #1;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL ooo_empty got %b exp 1", bus.empty); end
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    do_reset(1);
    for (int r = 0; r < 10; r++) begin
      idle(); bus.alloc_valid = 1; #1;
      checks++; if (bus.alloc_idx !== 2'(r % 4)) begin errors++; $display("FAIL wrap_alloc_idx round %0d got %0d exp %0d", r, bus.alloc_idx, r % 4); end
      tick();
      v = 8'($urandom);
      idle(); bus.fill_valid = 1; bus.fill_idx = 2'(r % 4); bus.fill_data = v; #1;
      checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL wrap_full round %0d got %b exp 0", r, bus.full); end
      tick();
      idle(); bus.drain_ready = 1; #1;
      checks++;
      if (bus.drain_valid !== 1'b1 || bus.drain_data !== v) begin
        errors++; $display("FAIL wrap_drain round %0d got v %b data %h exp v 1 data %h", r, bus.drain_valid, bus.drain_data, v);
      end
      tick();
    end
  endtask

  task automatic test_full_drain();
    do_reset(1);
    for (int i = 0; i < 4; i++) begin idle(); bus.alloc_valid = 1; tick(); end
    for (int i = 0; i < 4; i++) begin
      idle(); bus.fill_valid = 1; bus.fill_idx = 2'(i); bus.fill_data = 8'h50 + 8'(i); tick();
    end
    idle(); bus.alloc_valid = 1; bus.drain_ready = 1; #1;
    checks++; if (bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL fulldrain_alloc_ready got %b exp 0", bus.alloc_ready); end
    checks++; if (bus.drain_idx !== 2'd0) begin errors++; $display("FAIL fulldrain_head got %0d exp 0", bus.drain_idx); end
    tick();
    idle(); #1;
    checks++; if (bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL fulldrain_alloc_ready_next got %b exp 1", bus.alloc_ready); end
    checks++; if (bus.alloc_idx !== 2'd0) begin errors++; $display("FAIL fulldrain_alloc_idx got %0d exp 0", bus.alloc_idx); end
    checks++; if (bus.drain_idx !== 2'd1) begin errors++; $display("FAIL fulldrain_head_next got %0d exp 1", bus.drain_idx); end
    do_reset(1);
  endtask

  task automatic test_errors();
    do_reset(1);
    for (int i = 0; i < 2; i++) begin idle(); bus.alloc_valid = 1; tick(); end
    idle(); bus.fill_valid = 1; bus.fill_idx = 2'd3; bus.fill_data = 8'hEE; tick();
    idle(); #1;
    checks++; if (bus.fill_err !== 1'b1) begin errors++; $display("FAIL err_unalloc got %b exp 1", bus.fill_err); end
    checks++; if (bus.drain_valid !== 1'b0) begin errors++; $display("FAIL err_no_drain got %b exp 0", bus.drain_valid); end
    bus.fill_valid = 1; bus.fill_idx = 2'd0; bus.fill_data = 8'h11; tick();
    bus.fill_data = 8'h22; tick();
    bus.fill_idx = 2'd1; bus.fill_data = 8'h33; tick();
    idle(); bus.drain_ready = 1; #1;
    checks++; if (bus.drain_data !== 8'h11 || bus.drain_idx !== 2'd0) begin errors++; $display("FAIL err_keep_first got idx %0d data %h exp idx 0 data 11", bus.drain_idx, bus.drain_data); end
    tick(); #1;
    checks++; if (bus.drain_data !== 8'h33 || bus.drain_idx !== 2'd1) begin errors++; $display("FAIL err_order got idx %0d data %h exp idx 1 data 33", bus.drain_idx, bus.drain_data); end
    tick(); idle(); repeat (3) tick(); #1;
    checks++; if (bus.fill_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", bus.fill_err); end
    do_reset(1); #1;
    checks++; if (bus.fill_err !== 1'b0) begin errors++; $display("FAIL err_reset_clear got %b exp 0", bus.fill_err); end
    bus.fill_valid = 1; bus.fill_idx = 2'd0; tick(); idle(); #1;
    checks++; if (bus.fill_err !== m_err || m_err !== 1'b1) begin errors++; $display("FAIL err_late_fill got %b exp 1", bus.fill_err); end
  endtask

  task automatic test_random();
    int cand[$];
    do_reset(1);
    for (int c = 0; c < 400; c++) begin
      idle();
      bus.alloc_valid = ($urandom_range(0, 2) != 0);
      bus.drain_ready = ($urandom_range(0, 3) != 0);
      cand.delete();
      foreach (q[k]) if (!m_filled[q[k]]) cand.push_back(q[k]);
      if ($urandom_range(0, 1) == 1) begin
        bus.fill_valid = 1;
        bus.fill_data  = 8'($urandom);
        if (cand.size() > 0 && $urandom_range(0, 15) != 0)
          bus.fill_idx = 2'(cand[$urandom_range(0, cand.size() - 1)]);
        else
          bus.fill_idx = 2'($urandom_range(0, SIZE - 1));
      end
      #1;
      checks++;
      if (bus.alloc_ready !== !exp_full() || bus.full !== exp_full() || bus.empty !== (q.size() == 0) || bus.alloc_idx !== 2'(next_idx)) begin
        errors++; $display("FAIL rand_status cyc %0d got rdy %b full %b empty %b aidx %0d exp occ %0d aidx %0d", c, bus.alloc_ready, bus.full, bus.empty, bus.alloc_idx, q.size(), next_idx);
      end
      checks++;
      if (bus.drain_valid !== exp_dv() || bus.fill_err !== m_err) begin
        errors++; $display("FAIL rand_valid cyc %0d got dv %b err %b exp dv %b err %b", c, bus.drain_valid, bus.fill_err, exp_dv(), m_err);
      end
      if (exp_dv()) begin
        checks++;
        if (bus.drain_idx !== 2'(q[0]) || bus.drain_data !== m_data[q[0]]) begin
          errors++; $display("FAIL rand_drain cyc %0d got idx %0d data %h exp idx %0d data %h", c, bus.drain_idx, bus.drain_data, q[0], m_data[q[0]]);
        end
      end
      tick();
    end
  endtask

  initial begin
    reset = 1;
    idle();
    q.delete(); next_idx = 0; m_err = 0;
    test_reset();
    test_in_order();
    test_out_of_order();
    test_wrap();
    test_full_drain();
    test_errors();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vx_index_reorder.md
Name: VX_index_reorder

Overview:
- Tag-ordered completion buffer: the consumer side of index-based tracking.
- Hands out slot indices in strict ring order on allocate.
- Accepts tagged completions (index + data) in any order.
- Retires entries to the consumer strictly in allocation order, freeing each slot as it retires.
- Sits between a request issuer, which tags outgoing requests with the allocated index, and an in-order response consumer, e.g. memory or cache response reordering.

Parameters:
- DATAW, 1, width of completion payload
- SIZE, 8, number of slots; power of two, >= 2
- ADDRW, LOG2UP(SIZE), slot index width (derived; do not override)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- alloc_valid  input  1  issuer requests a slot
- alloc_ready  output  1  slot available (= !full)
- alloc_idx  output  ADDRW  index granted on alloc handshake (current tail)
- fill_valid  input  1  completion arriving
- fill_idx  input  ADDRW  slot the completion belongs to
- fill_data  input  DATAW  completion payload
- drain_valid  output  1  head slot allocated and filled
- drain_ready  input  1  consumer accepts head
- drain_idx  output  ADDRW  index of head slot
- drain_data  output  DATAW  payload of head slot
- fill_err  output  1  sticky: fill hit an unallocated or already-filled slot
- empty  output  1  no slots allocated
- full  output  1  all SIZE slots allocated

Behaviour:
- Reset is synchronous, active-low: all state clears on the clk edge where reset==0.
- Reset values:
  - head = tail = 0; all alloc and filled bits = 0
  - alloc_ready = 1, alloc_idx = 0, drain_valid = 0, drain_idx = 0
  - fill_err = 0, empty = 1, full = 0
  - drain_data is don't-care while drain_valid = 0
- Pointers: head and tail are ADDRW+1 bits, with the MSB as the wrap bit.
  - empty = (head == tail)
  - full = (low bits equal) && (wrap bits differ)
  - Slot index = low ADDRW bits. Both pointers wrap modulo 2*SIZE.
- Allocate: on alloc_valid && alloc_ready, alloc_idx = tail[ADDRW-1:0] that cycle.
  - Next cycle: alloc[tail] = 1, filled[tail] = 0, tail increments.
  - No bypass when full: a drain in the same cycle does not make alloc_ready = 1 that cycle.
- Fill: on fill_valid, if alloc[fill_idx] && !filled[fill_idx]:
  - fill_data is written to storage;
  - filled[fill_idx] = 1 on the next edge.
  - Otherwise storage is unchanged and fill_err is set (sticky until reset).
- Drain: drain_valid = !empty && filled[head], combinational from registered state.
  - drain_idx and drain_data are driven from the head slot.
  - On drain_valid && drain_ready: alloc[head] and filled[head] clear, head increments.
- Latency:
  - A fill in cycle N is visible on drain_valid in cycle N+1 (no fill->drain bypass).
  - An alloc in cycle N makes empty deassert in cycle N+1.
- Simultaneous events:
  - Alloc + drain in the same cycle: both apply and occupancy is unchanged. Alloc of the slot being freed is impossible because full blocks it.
  - Fill + drain in the same cycle to different slots: both apply.
  - A fill to the head slot while drain_valid=0 is legal and takes effect next cycle.
- drain_valid must stay asserted with stable drain_idx and drain_data until accepted.
- Storage: registers when SIZE <= 16, otherwise a 1W/1R array with asynchronous read. Write port = fill; read port = head index.
- Reset mid-operation: all in-flight slots are discarded. Late fills after reset target unallocated slots, so they set fill_err and are dropped.

Decomposition:
- Shared package: none required.
  - ADDRW derivation uses the common LOG2UP macro.
  - Pointer width (ADDRW+1) is a localparam.
- One natural sub-module: VX_index_reorder_ptr. It is a wrap-bit ring pointer pair providing head, tail, empty and full, and is reusable by other in-order allocators.
- Storage stays inline.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release -> alloc_ready=1, empty=1, full=0, drain_valid=0, fill_err=0, alloc_idx=0.
- In-order, SIZE=4:
  - alloc x4 -> alloc_idx 0,1,2,3 and full=1 after the 4th;
  - fill idx 0..3 with data 0xA0..0xA3, drain_ready=1 -> drains 0xA0..0xA3 in order, then empty=1.
- Out-of-order: alloc 0,1,2, then fill 2 (0xC2), 0 (0xC0), 1 (0xC1) in consecutive cycles:
  - drain_valid rises the cycle after the fill of 0, drain idx0=0xC0;
  - idx1 then idx2 follow back-to-back after the fill of 1.
- Wrap-around:
  - 10 alloc/fill/drain rounds with SIZE=4 -> alloc_idx sequence 0,1,2,3,0,1,...;
  - full never asserts with occupancy 1;
  - drained data matches fills.
- Full with simultaneous drain:
  - fill all 4 slots, assert alloc_valid and drain_ready together -> alloc_ready=0 that cycle, head advances;
  - next cycle alloc_ready=1 and alloc_idx=0.
- Errors:
  - fill idx 3 while only 0..1 are allocated -> fill_err=1, drain order unaffected;
  - a second fill of idx 0 -> storage keeps the first data;
  - fill_err clears only on reset.
